// File: rtl/multi_cycle_controller.sv
// Control FSM for the multi-cycle RV32I core: one state per clock, all
// enables and selects decoded combinationally from the state and the IR fields.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_function,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JAL, S_LUI
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011, IMM_U = 3'b100;

  localparam logic [1:0] A_PC = 2'b00, A_OLD_PC = 2'b01, A_REG = 2'b10;
  localparam logic [1:0] B_REG = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011, ALU_XOR = 3'b100, ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110, ALU_PASS_B = 3'b111;

  localparam logic [1:0] RES_ALU_OUT = 2'b00, RES_MDR = 2'b01, RES_ALU = 2'b10;

  state_e state, next_state;

  // The ALU has no shifter, so f3 001/101 decode as illegal.
  function automatic logic alu_f3_ok(input logic [2:0] f);
    return !(f == 3'b001 || f == 3'b101);
  endfunction

  function automatic logic [2:0] alu_map(input logic [2:0] f, input logic sub);
    case (f)
      3'b000:  alu_map = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_map = ALU_AND;
      3'b110:  alu_map = ALU_OR;
      3'b100:  alu_map = ALU_XOR;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      default: alu_map = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first; a path that skips an assignment
    // would otherwise infer a latch.
    next_state   = state;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    imm_src      = IMM_I;
    alu_src_a    = A_PC;
    alu_src_b    = B_REG;
    alu_function = ALU_ADD;
    result_src   = RES_ALU_OUT;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    illegal      = 1'b0;

    case (state)
      S_FETCH: begin
        ir_write     = 1'b1;
        old_pc_write = 1'b1;
        alu_src_b    = B_FOUR;
        result_src   = RES_ALU;
        pc_write     = 1'b1;
        next_state   = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jal targets are precomputed here into alu_out.
        alu_src_a = A_OLD_PC;
        alu_src_b = B_IMM;
        imm_src   = (opcode == OP_BRANCH) ? IMM_B :
                    (opcode == OP_JAL)    ? IMM_J : IMM_I;
        next_state = S_FETCH;
        case (opcode)
          OP_LOAD, OP_STORE: if (f3 == 3'b010) next_state = S_MEM_ADR;
          OP_R: if (alu_f3_ok(f3) &&
                    (f7 == F7_BASE || (f3 == 3'b000 && f7 == F7_SUB)))
                  next_state = S_EXEC_R;
          OP_I:      if (alu_f3_ok(f3)) next_state = S_EXEC_I;
          OP_BRANCH: if (f3[2:1] != 2'b01) next_state = S_BRANCH;
          OP_JAL:    next_state = S_JAL;
          OP_JALR:   if (f3 == 3'b000) next_state = S_JALR_ADR;
          OP_LUI:    next_state = S_LUI;
          default:   ;
        endcase
        illegal = (next_state == S_FETCH);
      end
      S_MEM_ADR: begin
        alu_src_a  = A_REG;
        alu_src_b  = B_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a    = A_REG;
        alu_function = alu_map(f3, f7 == F7_SUB);
        next_state   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a    = A_REG;
        alu_src_b    = B_IMM;
        alu_function = alu_map(f3, 1'b0);
        next_state   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = A_REG;
        case (f3[2:1])
          2'b10:   alu_function = ALU_SLT;
          2'b11:   alu_function = ALU_SLTU;
          default: alu_function = ALU_SUB;
        endcase
        // beq/bge/bgeu take on zero; bne/blt/bltu on non-zero.
        pc_write   = zero ^ (f3[0] ^ f3[2]);
        next_state = S_FETCH;
      end
      S_JALR_ADR: begin
        alu_src_a  = A_REG;
        alu_src_b  = B_IMM;
        next_state = S_JAL;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        alu_src_a  = A_OLD_PC;
        alu_src_b  = B_FOUR;
        next_state = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b    = B_IMM;
        imm_src      = IMM_U;
        alu_function = ALU_PASS_B;
        result_src   = RES_ALU;
        reg_write    = 1'b1;
        next_state   = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset suppresses every write immediately, not just from the next edge.
    if (reset) begin
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      old_pc_write = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Control FSM for the multi-cycle RV32I core. It decodes `opcode`/`f3`/`f7` latched in the IR and the ALU `zero` flag, and drives every enable and select of the multi-cycle datapath one state per clock. All control outputs are combinational functions of the current state and decode inputs (Moore plus decode-dependent selects). There are no registered outputs.

## Interface
Parameters:
- none. Encodings are fixed and shared with the datapath.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; state returns to FETCH
- `opcode`  in  7  IR[6:0]
- `f3`  in  3  IR[14:12]
- `f7`  in  7  IR[31:25]
- `zero`  in  1  ALU result == 0
- `adr_src`  out  1  memory address: 0 = PC, 1 = result bus
- `mem_write`  out  1  memory write enable
- `ir_write`  out  1  IR load enable
- `imm_src`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- `alu_src_a`  out  2  00 PC, 01 old_pc, 10 A register
- `alu_src_b`  out  2  00 B register, 01 immediate, 10 constant 4
- `alu_function`  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 pass_b
- `result_src`  out  2  00 alu_out register, 01 MDR, 10 ALU output (direct)
- `reg_write`  out  1  register file write enable
- `pc_write`  out  1  PC load enable (PC ← result bus)
- `old_pc_write`  out  1  old_pc load enable
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported encoding

## Operation
- Default for every state: all enables 0, selects 000/00, `illegal` 0.
- FETCH:
  - `adr_src`=0, `ir_write`=1, `old_pc_write`=1.
  - ALU computes PC+4: a=00, b=10, add.
  - `result_src`=10, `pc_write`=1.
  - Next state: DECODE.
- DECODE:
  - ALU computes old_pc+imm: a=01, b=01, add.
  - `imm_src` is taken from the opcode: branch→B, jal→J, else I.
  - Next state by opcode:
    - 0000011 with f3=010 → MEM_ADR.
    - 0100011 with f3=010 → MEM_ADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 with f3=000 → JALR_ADR.
    - 0110111 → LUI.
    - Anything else: `illegal`=1 and next state FETCH.
  - Unsupported f3/f7 combinations under R/I/branch also take the illegal path.
- MEM_ADR:
  - a=10, b=01, add.
  - `imm_src` = S for stores, I for loads.
  - Next state: MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: `adr_src`=1, `result_src`=00; next state MEM_WB.
- MEM_WB: `result_src`=01, `reg_write`=1; next state FETCH.
- MEM_WRITE: `adr_src`=1, `result_src`=00, `mem_write`=1; next state FETCH.
- EXEC_R: a=10, b=00; next state ALU_WB. Function map by f3:
  - 000: add, or sub when f7=0100000.
  - 111: and. 110: or. 100: xor. 010: slt. 011: sltu.
  - Any other f7 value is illegal.
- EXEC_I: a=10, b=01, I-imm; next state ALU_WB. Function map is the same as EXEC_R, except f3=000 is always add and f7 is ignored.
- ALU_WB: `result_src`=00, `reg_write`=1; next state FETCH.
- BRANCH:
  - a=10, b=00, `result_src`=00 (target already in alu_out from DECODE).
  - beq (000): sub, `pc_write`=zero.
  - bne (001): sub, `pc_write`=!zero.
  - blt (100): slt, `pc_write`=!zero.
  - bge (101): slt, `pc_write`=zero.
  - bltu (110) / bgeu (111): sltu, with the same `zero` polarity as blt/bge.
  - Next state: FETCH.
- JALR_ADR: a=10, b=01, I-imm, add; next state JAL.
- JAL:
  - `result_src`=00 and `pc_write`=1, so PC ← alu_out (target).
  - ALU computes old_pc+4 (a=01, b=10, add) into alu_out.
  - Next state: ALU_WB.
- LUI: b=01, U-imm, pass_b, `result_src`=10, `reg_write`=1; next state FETCH.
- The JALR target LSB is not cleared. A misaligned target is a software error.

## Timing
- While `reset`=1, every enable output is forced to 0, whatever the state.
- The first rising edge with `reset`=0 is the first FETCH edge.
- Reset asserted mid-instruction aborts it at the next edge: no further writes, and the state becomes FETCH.
- Cycles per instruction:
  - lw 5, sw 4, R/I-type 4, jal 4, jalr 5.
  - branch 3 (taken or not), lui 3, illegal 2.
- `pc_write` and `reg_write` are never both 1, except that FETCH updates PC together with `ir_write`/`old_pc_write`.
- `mem_write` is high for exactly one cycle per store.

## Test plan
- Reset held 3 cycles, then released → all enables stay 0 during reset; the first cycle after release shows `ir_write`=`old_pc_write`=`pc_write`=1 with a=00, b=10.
- `lw` (opcode 0000011, f3 010) → states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB. `reg_write` is 1 only in cycle 5, with `result_src`=01.
- `sub` (0110011, f3 000, f7 0100000) → EXEC_R drives `alu_function`=001, then ALU_WB writes. A total of 4 cycles.
- Branches:
  - `beq` with `zero`=1 → `pc_write`=1 in cycle 3.
  - Same instruction with `zero`=0 → `pc_write` stays 0.
  - `bge` with `zero`=1 → `pc_write`=1 and `alu_function`=101.
- `jalr` → PC load occurs in cycle 4 (JAL state) and rd is written in cycle 5 with `result_src`=00.
- Illegal opcode 1111111 → `illegal`=1 in DECODE, no writes, back to FETCH on cycle 3.
- `reset` asserted during MEM_READ → no `reg_write` occurs; FETCH follows once reset drops.
